n64_response_scheduler: RTL and testbench

Sequences the console-facing reply path of the controller emulator. Accepts a decoded command byte from the line receiver, waits a bus turnaround gap, then drives the shared byte transmitter and stop-bit transmitter through trigger/busy handshakes to emit the correct response. Sits between the command decoder and the byte/stop-bit transmitters, and owns the select that muxes their line outputs onto n64d.

---
 rtl/n64_response_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_n64_response_scheduler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_response_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : n64_response_scheduler
// Brief    : Sequences the console reply: turnaround gap, byte triggers, stop
//            bit, and the n64d line-source select.
//            Optional build macro N64_RESP_TIMEOUT_EN adds a busy watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module n64_response_scheduler #(
    parameter int TURNAROUND_CYCLES = 100,
    parameter int TIMEOUT_CYCLES    = 4095
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd,
    input  logic [31:0] ctrl_state,
    input  logic [7:0]  pak_status,
    output logic        byte_trigger,
    output logic [7:0]  tx_byte,
    input  logic        byte_busy,
    output logic        stop_trigger,
    input  logic        stop_busy,
    output logic        sel_stop,
    output logic        active,
    output logic        cmd_dropped
`ifdef N64_RESP_TIMEOUT_EN
    ,
    output logic        timeout_err
`endif
);

    localparam int                 c_gap_w    = $clog2(TURNAROUND_CYCLES + 1);
    localparam logic [c_gap_w-1:0] c_gap_load = c_gap_w'(TURNAROUND_CYCLES - 1);
    localparam logic [c_gap_w-1:0] c_gap_one  = c_gap_w'(1);

    if (TURNAROUND_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("n64_response_scheduler: cycle parameters must be >= 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GAP       = 3'd1,
        ST_LOAD      = 3'd2,
        ST_ARM       = 3'd3,
        ST_WAIT      = 3'd4,
        ST_STOP_LOAD = 3'd5,
        ST_STOP_ARM  = 3'd6,
        ST_STOP_WAIT = 3'd7
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [31:0]        r_buf;
    logic [2:0]         r_len;
    logic [2:0]         r_count;
    logic [c_gap_w-1:0] r_gap;
    logic [7:0]         r_tx_byte;
    logic               r_byte_trigger;
    logic               r_stop_trigger;
    logic               r_sel_stop;
    logic               r_active;
    logic               r_cmd_dropped;

    logic               w_cmd_ok;
    logic               w_accept;
    logic [2:0]         w_count_next;
    logic               w_timeout;

    assign w_cmd_ok     = (cmd == 8'h00) || (cmd == 8'h01) || (cmd == 8'hFF);
    assign w_accept     = (r_state == ST_IDLE) && cmd_valid && w_cmd_ok;
    assign w_count_next = r_count + 3'd1;

`ifdef N64_RESP_TIMEOUT_EN
    localparam int                  c_wdog_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_wdog_w-1:0] c_wdog_last = c_wdog_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_wdog_w-1:0] c_wdog_one  = c_wdog_w'(1);

    logic [c_wdog_w-1:0] r_wdog;
    logic                r_timeout_err;

    // Only a transmitter that is still busy can time out.
    assign w_timeout = ((r_state == ST_WAIT && byte_busy) ||
                        (r_state == ST_STOP_WAIT && stop_busy)) &&
                       (r_wdog == c_wdog_last);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if (r_state == ST_ARM || r_state == ST_STOP_ARM) begin
                r_wdog <= '0;
            end else if (r_state == ST_WAIT || r_state == ST_STOP_WAIT) begin
                r_wdog <= r_wdog + c_wdog_one;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:      if (w_accept) w_state_next = ST_GAP;
            ST_GAP:       if (r_gap == '0) w_state_next = ST_LOAD;
            ST_LOAD:      w_state_next = ST_ARM;
            ST_ARM:       w_state_next = ST_WAIT;
            ST_WAIT: begin
                if (w_timeout) begin
                    w_state_next = ST_IDLE;
                end else if (!byte_busy) begin
                    w_state_next = (w_count_next == r_len) ? ST_STOP_LOAD : ST_LOAD;
                end
            end
            ST_STOP_LOAD: w_state_next = ST_STOP_ARM;
            ST_STOP_ARM:  w_state_next = ST_STOP_WAIT;
            ST_STOP_WAIT: if (w_timeout || !stop_busy) w_state_next = ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf          <= '0;
            r_len          <= '0;
            r_count        <= '0;
            r_gap          <= '0;
            r_tx_byte      <= '0;
            r_byte_trigger <= 1'b0;
            r_stop_trigger <= 1'b0;
            r_sel_stop     <= 1'b0;
            r_active       <= 1'b0;
            r_cmd_dropped  <= 1'b0;
        end else begin
            // Anything not accepted in IDLE is reported, including mid-reply commands.
            r_cmd_dropped  <= cmd_valid && !w_accept;
            r_byte_trigger <= 1'b0;
            r_stop_trigger <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_buf    <= (cmd == 8'h01) ? ctrl_state
                                                   : {8'h05, 8'h00, pak_status, 8'h00};
                        r_len    <= (cmd == 8'h01) ? 3'd4 : 3'd3;
                        r_count  <= '0;
                        r_gap    <= c_gap_load;
                        r_active <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gap != '0) r_gap <= r_gap - c_gap_one;
                end
                ST_LOAD: begin
                    r_tx_byte      <= r_buf[31:24];
                    r_byte_trigger <= 1'b1;
                end
                ST_WAIT: begin
                    if (w_timeout) begin
                        r_active <= 1'b0;
                        r_count  <= '0;
                    end else if (!byte_busy) begin
                        r_buf   <= {r_buf[23:0], 8'h00};
                        r_count <= w_count_next;
                    end
                end
                ST_STOP_LOAD: begin
                    r_sel_stop     <= 1'b1;
                    r_stop_trigger <= 1'b1;
                end
                ST_STOP_WAIT: begin
                    if (w_timeout || !stop_busy) begin
                        r_sel_stop <= 1'b0;
                        r_active   <= 1'b0;
                        r_count    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign byte_trigger = r_byte_trigger;
    assign tx_byte      = r_tx_byte;
    assign stop_trigger = r_stop_trigger;
    assign sel_stop     = r_sel_stop;
    assign active       = r_active;
    assign cmd_dropped  = r_cmd_dropped;

endmodule
`default_nettype wire

// File: tb/tb_n64_response_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_n64_response_scheduler
// Brief    : Self-checking bench: vector table, transmitter model, byte scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_n64_response_scheduler;

    localparam int TURN       = 4;
    localparam int BYTE_BUSY  = 20;
    localparam int STOP_BUSY  = 6;

    logic        sys_clk    = 1'b0;
    logic        rst_n      = 1'b1;
    logic        cmd_valid  = 1'b0;
    logic [7:0]  cmd        = 8'h00;
    logic [31:0] ctrl_state = 32'h0;
    logic [7:0]  pak_status = 8'h00;
    logic        byte_trigger;
    logic [7:0]  tx_byte;
    logic        byte_busy  = 1'b0;
    logic        stop_trigger;
    logic        stop_busy  = 1'b0;
    logic        sel_stop;
    logic        active;
    logic        cmd_dropped;
`ifdef N64_RESP_TIMEOUT_EN
    logic        timeout_err;
`endif

    always #5 sys_clk = ~sys_clk;

    n64_response_scheduler #(
        .TURNAROUND_CYCLES(TURN)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd         (cmd),
        .ctrl_state  (ctrl_state),
        .pak_status  (pak_status),
        .byte_trigger(byte_trigger),
        .tx_byte     (tx_byte),
        .byte_busy   (byte_busy),
        .stop_trigger(stop_trigger),
        .stop_busy   (stop_busy),
        .sel_stop    (sel_stop),
        .active      (active),
        .cmd_dropped (cmd_dropped)
`ifdef N64_RESP_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_btrig  = 0;
    int n_strig  = 0;
    int n_drop   = 0;
    int first_trig_cyc = -1;
    int stop_drop_cyc  = -1;
    int cmd_cyc   = 0;
    int byte_left = 0;
    int stop_left = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] cs;
        logic [7:0]  ps;
        int          nbytes;
        logic [31:0] exp;
        logic        drop;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Transmitter model and scoreboard, sampled mid-cycle.
    always @(negedge sys_clk) begin
        if (cmd_dropped) n_drop++;
        if (byte_trigger) begin
            n_btrig++;
            if (first_trig_cyc < 0) first_trig_cyc = cyc;
            check("byte_trigger_while_busy", {31'd0, byte_busy}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_byte_trigger: got tx_byte 0x%0h with empty scoreboard", tx_byte);
            end else begin
                check("tx_byte", {24'd0, tx_byte}, {24'd0, exp_q.pop_front()});
            end
            byte_busy = 1'b1;
            byte_left = BYTE_BUSY;
        end else if (byte_left > 0) begin
            byte_left--;
            if (byte_left == 0) byte_busy = 1'b0;
        end
        if (stop_trigger) begin
            n_strig++;
            check("stop_trigger_while_busy", {31'd0, stop_busy}, 32'd0);
            check("sel_stop_at_stop_trigger", {31'd0, sel_stop}, 32'd1);
            stop_busy = 1'b1;
            stop_left = STOP_BUSY;
        end else if (stop_left > 0) begin
            stop_left--;
            if (stop_left == 0) begin
                stop_busy     = 1'b0;
                stop_drop_cyc = cyc;
            end
        end
    end

    task automatic push_bytes(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(w[31-8*i -: 8]);
    endtask

    task automatic send(input logic [7:0] c, input logic [31:0] cs, input logic [7:0] ps);
        @(negedge sys_clk);
        cmd_valid      = 1'b1;
        cmd            = c;
        ctrl_state     = cs;
        pak_status     = ps;
        first_trig_cyc = -1;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        cmd_cyc   = cyc;
    endtask

    task automatic wait_idle(input string name, output int idle_cyc);
        bit done = 1'b0;
        idle_cyc = -1;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge sys_clk);
            if (!active) begin
                done     = 1'b1;
                idle_cyc = cyc;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: active still 1 after 1000 cycles, required 0", name);
        end
    endtask

    task automatic wait_trig(input string name, input int target);
        bit done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge sys_clk);
            if (n_btrig >= target) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: saw %0d byte triggers, required %0d", name, n_btrig, target);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_byte_trigger"}, {31'd0, byte_trigger}, 32'd0);
        check({tag, "_stop_trigger"}, {31'd0, stop_trigger}, 32'd0);
        check({tag, "_sel_stop"},     {31'd0, sel_stop},     32'd0);
        check({tag, "_active"},       {31'd0, active},       32'd0);
        check({tag, "_cmd_dropped"},  {31'd0, cmd_dropped},  32'd0);
        check({tag, "_tx_byte"},      {24'd0, tx_byte},      32'd0);
`ifdef N64_RESP_TIMEOUT_EN
        check({tag, "_timeout_err"},  {31'd0, timeout_err},  32'd0);
`endif
    endtask

    initial begin
        int bt0, st0, d0, idle_cyc;

        vecs[0] = '{8'h01, 32'h8010_7F81, 8'h00, 4, 32'h8010_7F81, 1'b0};
        vecs[1] = '{8'h00, 32'h0000_0000, 8'h01, 3, 32'h0500_0100, 1'b0};
        vecs[2] = '{8'hFF, 32'h0000_0000, 8'h02, 3, 32'h0500_0200, 1'b0};
        vecs[3] = '{8'h42, 32'hFFFF_FFFF, 8'h00, 0, 32'h0000_0000, 1'b1};
        vecs[4] = '{8'h01, 32'h1234_5678, 8'hAA, 4, 32'h1234_5678, 1'b0};
        vecs[5] = '{8'h02, 32'h0000_0000, 8'h00, 0, 32'h0000_0000, 1'b1};

        #1 rst_n = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            bt0 = n_btrig;
            st0 = n_strig;
            d0  = n_drop;
            if (!vecs[i].drop) push_bytes(vecs[i].exp, vecs[i].nbytes);
            send(vecs[i].cmd, vecs[i].cs, vecs[i].ps);
            if (vecs[i].drop) begin
                repeat (2) @(negedge sys_clk);
                check("drop_count", n_drop - d0, 1);
                check("drop_active", {31'd0, active}, 32'd0);
                repeat (TURN + 4) @(negedge sys_clk);
                check("drop_no_trigger", n_btrig - bt0, 0);
            end else begin
                check("active_after_cmd", {31'd0, active}, 32'd1);
                wait_idle("reply_done", idle_cyc);
                check("first_trigger_latency", first_trig_cyc - cmd_cyc, TURN + 1);
                check("active_fall_latency", idle_cyc - stop_drop_cyc, 1);
                check("byte_trigger_count", n_btrig - bt0, vecs[i].nbytes);
                check("stop_trigger_count", n_strig - st0, 1);
                check("scoreboard_empty", exp_q.size(), 0);
                check("no_drop_on_valid", n_drop - d0, 0);
            end
        end

        // Snapshot must ignore ctrl_state changes during the gap.
        bt0 = n_btrig;
        push_bytes(32'h8010_7F81, 4);
        send(8'h01, 32'h8010_7F81, 8'h00);
        ctrl_state = 32'h0000_0000;
        wait_idle("snapshot_reply_done", idle_cyc);
        check("snapshot_scoreboard_empty", exp_q.size(), 0);
        check("snapshot_trigger_count", n_btrig - bt0, 4);

        // Command arriving mid-reply is dropped; reply continues intact.
        bt0 = n_btrig;
        st0 = n_strig;
        d0  = n_drop;
        push_bytes(32'h1122_3344, 4);
        send(8'h01, 32'h1122_3344, 8'h00);
        wait_trig("midreply_wait", bt0 + 2);
        @(negedge sys_clk);
        cmd_valid  = 1'b1;
        cmd        = 8'h01;
        ctrl_state = 32'hDEAD_BEEF;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        wait_idle("midreply_done", idle_cyc);
        repeat (2) @(negedge sys_clk);
        check("midreply_drop_count", n_drop - d0, 1);
        check("midreply_trigger_count", n_btrig - bt0, 4);
        check("midreply_stop_count", n_strig - st0, 1);
        check("midreply_scoreboard_empty", exp_q.size(), 0);

        // Asynchronous reset during the third byte's busy wait.
        bt0 = n_btrig;
        st0 = n_strig;
        push_bytes(32'hA1B2_C3D4, 4);
        send(8'h01, 32'hA1B2_C3D4, 8'h00);
        wait_trig("reset_wait", bt0 + 3);
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b0;
        #1 check_outputs_zero("async_reset");
        exp_q.delete();
        @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (BYTE_BUSY + 5) @(negedge sys_clk);
        check("reset_no_stop", n_strig - st0, 0);
        check("reset_no_more_bytes", n_btrig - bt0, 3);
        bt0 = n_btrig;
        st0 = n_strig;
        push_bytes(32'h0500_3300, 3);
        send(8'h00, 32'h0, 8'h33);
        wait_idle("post_reset_done", idle_cyc);
        check("post_reset_latency", first_trig_cyc - cmd_cyc, TURN + 1);
        check("post_reset_trigger_count", n_btrig - bt0, 3);
        check("post_reset_stop_count", n_strig - st0, 1);
        check("post_reset_scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at time limit");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
